mdu_iter: RTL and testbench
===========================

# mdu_iter

Parametrised iterative multiply/divide unit that sits beside the combinational ALU in the execute stage and owns the HI/LO register pair. It performs signed/unsigned multiply and divide over a configurable data width, one iteration per clock, behind a start/busy handshake. The datapath stalls on `busy` and reads results from `HI`/`LO`.

## Interface
- `WIDTH`, default 32, operand width in bits; must be ≥ 2. HI and LO are each WIDTH bits.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `start` input, 1 bit: request strobe, sampled on the rising edge of `clk`.
- `op` input, 3 bits: operation select.
  - 000 MULT
  - 001 MULTU
  - 010 DIV
  - 011 DIVU
  - 100 MTHI
  - 101 MTLO
  - others are no-op.
- `A` input, WIDTH bits: multiplicand or dividend; also the data for MTHI/MTLO.
- `B` input, WIDTH bits: multiplier or divisor.
- `busy` output, 1 bit: high while an operation is in progress.
- `done` output, 1 bit: one-cycle pulse when HI/LO take a mul/div result.
- `HI` output, WIDTH bits: product upper half, or remainder.
- `LO` output, WIDTH bits: product lower half, or quotient.

## Operation
- The FSM has three states: IDLE, CALC and FIX.
- **IDLE:**
  - `start`=1 with MTHI/MTLO: write `A` to HI/LO at that edge. No busy, no done.
  - `start`=1 with a mul/div op:
    - Latch the operand magnitudes. For signed ops, use the two's-complement absolute value.
    - Latch the result sign flags.
    - Clear the iteration counter, which is $clog2(WIDTH+1) bits.
    - Go to CALC.
  - Reserved `op` values: remain in IDLE.
- **CALC:**
  - Multiply: one shift-add step per cycle into a 2·WIDTH accumulator.
  - Divide: one restoring shift-subtract step per cycle.
  - After WIDTH iterations, go to FIX.
- **FIX:**
  - Apply the sign correction:
    - The product is negated over 2·WIDTH bits if the operand signs differ.
    - The quotient is negated if the operand signs differ.
    - The remainder takes the sign of the dividend.
  - Write HI/LO, pulse `done`, return to IDLE.
- **Divide by zero:**
  - Runs the full latency.
  - Result is HI = original `A`, LO = all ones, for both DIV and DIVU.
- **Signed overflow:** DIV of the most negative value by −1 gives LO = most negative value and HI = 0. This is modulo arithmetic with no trap.
- **Requests while busy:** `start` is ignored for every op, including MTHI/MTLO. HI/LO hold their previous values until FIX.
- `op`, `A` and `B` are only sampled at the accepting edge. They may change freely afterwards.

## Timing
- **Reset:**
  - Takes effect immediately and asynchronously, including mid-operation.
  - State goes to IDLE; `busy`=0, `done`=0, HI=0, LO=0, counter=0.
  - An in-flight result is discarded.
- **Edge numbering:** E0 is the accepting edge. E1…E_WIDTH are the CALC iterations. E_(WIDTH+1) is FIX.
- **`busy`:** goes 1 after E0 and back to 0 after E_(WIDTH+1). It is high for exactly WIDTH+1 cycles.
- **`done`:** 1 for the single cycle after E_(WIDTH+1). HI/LO are valid in that same cycle.
- **Back-to-back operations:** a new `start` may be accepted at the edge that ends the `done` cycle. `busy` is already 0 in that cycle.
- **MTHI/MTLO:** HI/LO are visible in the cycle after the accepting edge.
- **Output registers:** HI, LO, `busy` and `done` are all registered, with no combinational path from the inputs.

## Configuration
- **`MDU_DIV_EN` defined:**
  - DIV/DIVU are implemented as described above.
- **`MDU_DIV_EN` undefined:**
  - The divider datapath is removed.
  - DIV/DIVU are treated as reserved no-ops: no busy, no done, HI/LO unchanged.
  - Multiply, MTHI, MTLO and all timing are unchanged.

## Test plan
All values below are at WIDTH=32.
- **MULTU:** `A`=0xFFFFFFFF, `B`=0xFFFFFFFF → after 33 busy cycles, `done`=1, HI=0xFFFFFFFE, LO=0x00000001.
- **MULT:** `A`=0xFFFFFFFD (−3), `B`=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- **DIV:**
  - `A`=0xFFFFFFF9 (−7), `B`=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - `A`=0x80000000, `B`=0xFFFFFFFF → LO=0x80000000, HI=0.
- **DIVU by zero:** `A`=0x64, `B`=0 → HI=0x64, LO=0xFFFFFFFF, `done` after 33 busy cycles.
- **Requests while busy:** MULTU 2×3 started, then MTHI `A`=0x55 and MULT strobed while busy → both ignored; final HI=0, LO=6. A following MTLO `A`=0xAA gives LO=0xAA one cycle later.
- **Reset mid-operation:** assert `rst` at cycle 10 of a DIVU → `busy`=0, HI=LO=0 immediately. No `done` pulse follows.

Source files
------------

// File: rtl/mdu_iter_if.sv
// Purpose : bundle of the mdu_iter request/result signals (start/op/A/B in, busy/done/HI/LO out).
// Latency : none, wiring only.
// Backpressure: none here; the master must hold off new requests while busy is high.
// Ports   : start, op[2:0], A, B (master -> slave); busy, done, HI, LO (slave -> master).
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  // The datapath issuing requests.
  modport master (
    output start, op, A, B,
    input  busy, done, HI, LO
  );

  // The multiply/divide unit.
  modport slave (
    input  start, op, A, B,
    output busy, done, HI, LO
  );
endinterface

// File: rtl/mdu_iter.sv
// Purpose : iterative signed/unsigned multiply/divide unit owning the HI/LO register pair.
// Latency : mul/div busy for WIDTH+1 cycles, done pulses the cycle after; MTHI/MTLO visible next cycle.
// Backpressure: start is ignored for every op while busy; the caller stalls on busy.
// Ports   : clk, rst (async active-high), bus (mdu_iter_if.slave: start/op/A/B in, busy/done/HI/LO out).
// Config  : define MDU_DIV_EN to build the divider; without it DIV/DIVU are no-ops.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  mdu_iter_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_DIV_EN
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  // Multiply: {partial product upper, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;      // multiplicand or divisor magnitude
  logic                 neg_q, neg_d;      // negate product / quotient in FIX
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef MDU_DIV_EN
  logic                 is_div_q, is_div_d;
  logic                 neg_rem_q, neg_rem_d; // remainder follows the dividend sign
`endif

  // Request decode and operand magnitudes.
  logic                 is_mul_op, is_div_op, is_signed_op, accept;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;

  always_comb begin
    is_mul_op    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
`ifdef MDU_DIV_EN
    is_div_op    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    is_signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
`else
    is_div_op    = 1'b0;
    is_signed_op = (bus.op == OP_MULT);
`endif
    accept = bus.start && (state_q == S_IDLE) && (is_mul_op || is_div_op);
    a_neg  = is_signed_op && bus.A[WIDTH-1];
    b_neg  = is_signed_op && bus.B[WIDTH-1];
    a_mag  = a_neg ? (~bus.A + WIDTH'(1)) : bus.A;
    b_mag  = b_neg ? (~bus.B + WIDTH'(1)) : bus.B;
  end

  // One shift-add multiply step: add multiplicand into the upper half when
  // the outgoing multiplier bit is set, then shift the whole accumulator right.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef MDU_DIV_EN
  // One restoring divide step. The shifted remainder needs WIDTH+1 bits for
  // the compare, but the difference always fits in WIDTH bits.
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_sub;
  logic [2*WIDTH-1:0]   div_next;
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_sub   = div_shift[WIDTH-1:0] - opb_q;
  assign div_next  = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
`endif

  logic [2*WIDTH-1:0]   prod_fix;
  assign prod_fix = neg_q ? -acc_q : acc_q;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CALC;
      S_CALC:  if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs and datapath.
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opb_d  = opb_q;
    neg_d  = neg_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    busy_d = (state_d != S_IDLE);
`ifdef MDU_DIV_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.op == OP_MTHI)) hi_d = bus.A;
        if (bus.start && (bus.op == OP_MTLO)) lo_d = bus.A;
        if (accept) begin
          cnt_d = '0;
          acc_d = {{WIDTH{1'b0}}, a_mag};
          opb_d = b_mag;
          neg_d = a_neg ^ b_neg;
`ifdef MDU_DIV_EN
          is_div_d  = is_div_op;
          neg_rem_d = a_neg;
          // Divide by zero: run the raw dividend through unsigned with no sign
          // fix-up. A zero divisor makes every step subtract, so the quotient
          // fills with ones and the remainder ends up equal to the raw A.
          if (is_div_op && (bus.B == '0)) begin
            acc_d     = {{WIDTH{1'b0}}, bus.A};
            neg_d     = 1'b0;
            neg_rem_d = 1'b0;
          end
`endif
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CW'(1);
`ifdef MDU_DIV_EN
        acc_d = is_div_q ? div_next : mul_next;
`else
        acc_d = mul_next;
`endif
      end
      S_FIX: begin
        done_d = 1'b1;
        hi_d   = prod_fix[2*WIDTH-1:WIDTH];
        lo_d   = prod_fix[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          lo_d = neg_q     ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
          hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
`endif
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MDU_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef MDU_DIV_EN
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Purpose : self-checking bench for mdu_iter at WIDTH=32 with a scoreboard and arithmetic reference model.
// Latency : models busy for WIDTH+1 cycles after the accepting edge, done in the cycle after that.
// Backpressure: models start as ignored while an operation is in flight.
module tb_mdu_iter;

  localparam int W = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(W)) bus ();

  mdu_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int errors   = 0;
  int edge_n   = 0;      // number of rising edges seen so far
  int acc_edge = -1000;  // edge number that accepted the last mul/div
  int free_at  = 0;      // first edge at which a new request is accepted

  logic [W-1:0]   mdl_hi = '0;
  logic [W-1:0]   mdl_lo = '0;
  logic [2*W-1:0] exp_q[$];

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {HI, LO}.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    case (op)
      OP_MULT:  res = sa * sb;
      OP_MULTU: res = {32'b0, a} * {32'b0, b};
      OP_DIV: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else        res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic bit is_calc_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (DIV_EN && ((op == OP_DIV) || (op == OP_DIVU)));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called at a falling edge; strobes start for one rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int e;
    bit acc;
    e   = edge_n + 1;
    acc = (e >= free_at);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    if (acc) begin
      if (is_calc_op(op)) begin
        exp_q.push_back(ref_model(op, a, b));
        acc_edge = e;
        free_at  = e + W + 2;
      end else if (op == OP_MTHI) begin
        mdl_hi = a;
      end else if (op == OP_MTLO) begin
        mdl_lo = a;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'($urandom_range(0, 7));
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  task automatic wait_free();
    while (edge_n + 1 < free_at) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: checks handshake timing every cycle, pops the scoreboard on done.
  initial begin
    logic [2*W-1:0] exp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("busy", bus.busy, (edge_n >= acc_edge) && (edge_n <= acc_edge + W));
        check("done", bus.done, edge_n == acc_edge + W + 1);
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected: got done=1 expected no pending result (t=%0t)", $time);
          end else begin
            exp    = exp_q.pop_front();
            mdl_hi = exp[2*W-1:W];
            mdl_lo = exp[W-1:0];
          end
        end
        check("HI", bus.HI, mdl_hi);
        check("LO", bus.LO, mdl_lo);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.A     = '0;
    bus.B     = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_HI",   bus.HI,   0);
    check("rst_LO",   bus.LO,   0);
    rst = 1'b0;
    @(negedge clk);

    // Directed arithmetic cases, each issued as soon as the unit frees up.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_free();
    issue(OP_MULT,  32'hFFFF_FFFD, 32'd5);         wait_free();
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2);         wait_free();
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF); wait_free();
    issue(OP_DIVU,  32'h0000_0064, 32'd0);         wait_free();
    issue(OP_DIV,   32'hFFFF_FF00, 32'd0);         wait_free();
    issue(OP_MULT,  32'h8000_0000, 32'h8000_0000); wait_free();
    issue(OP_MTHI,  32'h1234_5678, 32'd0);
    issue(OP_MTLO,  32'h9ABC_DEF0, 32'd0);
    issue(3'b110,   32'hDEAD_BEEF, 32'd1);
    idle(2);

    // Requests while busy are ignored, then MTLO lands one cycle later.
    issue(OP_MULTU, 32'd2, 32'd3);
    idle(3);
    issue(OP_MTHI,  32'h55, 32'd0);
    idle(5);
    issue(OP_MULT,  32'd7, 32'd9);
    wait_free();
    issue(OP_MTLO,  32'hAA, 32'd0);
    idle(2);

    // Randomised mix, sometimes back-to-back, sometimes strobing while busy.
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      if ($urandom_range(0, 1) == 1) wait_free();
      else                           idle($urandom_range(0, 3));
      issue(op, a, b);
    end
    wait_free();
    idle(3);

    // Asynchronous reset in the tenth busy cycle discards the result.
    issue(DIV_EN ? OP_DIVU : OP_MULTU, $urandom, $urandom | 32'd1);
    idle(9);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_HI",   bus.HI,   0);
    check("midrst_LO",   bus.LO,   0);
    exp_q.delete();
    mdl_hi   = '0;
    mdl_lo   = '0;
    acc_edge = -1000;
    free_at  = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(W + 5);
    check("no_result_after_reset", exp_q.size(), 0);

    issue(OP_MULTU, 32'd6, 32'd7);
    wait_free();
    idle(2);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
